// File: rtl/watchdog_multi_if.sv
// Signal bundle for the multi-channel watchdog. The bench drives it through
// the master modport, and the watchdog core sits on the slave modport.
interface watchdog_multi_if #(
  parameter int NCH = 2
);
  logic           wdis_n;
  logic [NCH-1:0] wdog_n;
  logic [NCH-1:0] ch_en;
  logic           vblank;
  logic           clr_cause;
  logic           wdreset_n;
  logic [NCH-1:0] warn;
  logic [NCH-1:0] trip_cause;
  logic [7:0]     trip_count;

  modport master (
    output wdis_n, wdog_n, ch_en, vblank, clr_cause,
    input  wdreset_n, warn, trip_cause, trip_count
  );

  modport slave (
    input  wdis_n, wdog_n, ch_en, vblank, clr_cause,
    output wdreset_n, warn, trip_cause, trip_count
  );
endinterface

// File: rtl/watchdog_multi.sv
// Multi-channel watchdog. Each channel counts vblank edges between kicks.
// A starved channel fires a fixed-length reset pulse, followed by a vblank holdoff.
module watchdog_multi #(
  parameter int NCH        = 2,
  parameter int CNT_W      = 4,
  parameter int TRIP       = 8,
  parameter int WARN       = 6,
  parameter int PULSE_LEN  = 16,
  parameter int HOLD_EDGES = 2
) (
  input logic            clk,
  input logic            reset,
  watchdog_multi_if.slave bus
);

  typedef enum logic [1:0] {RUN, FIRE, HOLD} state_t;

  localparam logic [CNT_W-1:0] TRIP_V     = CNT_W'(TRIP);
  localparam logic [CNT_W-1:0] WARN_V     = CNT_W'(WARN);
  localparam logic [7:0]       PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [3:0]       HOLD_LAST  = 4'((HOLD_EDGES == 0) ? 0 : HOLD_EDGES - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt [NCH];
  logic             r_vblankD;
  logic             r_armed;
  logic [7:0]       r_pulseCnt;
  logic [3:0]       r_holdCnt;
  logic             r_wdresetN;
  logic [NCH-1:0]   r_tripCause;
  logic [7:0]       r_tripCount;
  logic             w_edge;
  logic [NCH-1:0]   w_tripMask;
  logic             w_trip;
  logic             w_pulseDone;
  logic             w_holdDone;
  logic [NCH-1:0]   w_warn;

  // r_armed masks the first clock after reset, so a vblank already high is not seen as an edge.
  assign w_edge      = bus.vblank & ~r_vblankD & r_armed;
  assign w_pulseDone = (r_pulseCnt == PULSE_LAST);
  assign w_holdDone  = w_edge && (r_holdCnt == HOLD_LAST);
  assign w_trip      = (r_state == RUN) && (|w_tripMask);

  always_comb begin
    w_tripMask = '0;
    w_warn     = '0;
    for (int i = 0; i < NCH; i++) begin
      w_tripMask[i] = bus.ch_en[i] && (r_cnt[i] == TRIP_V);
      w_warn[i]     = (r_state == RUN) && bus.ch_en[i] && (r_cnt[i] >= WARN_V);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN:  if (w_trip) w_nextState = FIRE;
      FIRE: if (w_pulseDone) w_nextState = (HOLD_EDGES == 0) ? RUN : HOLD;
      HOLD: if (w_holdDone) w_nextState = RUN;
      default: w_nextState = RUN;
    endcase
  end

  // The pulse output is registered from the next-state decode, so it lines up exactly with FIRE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_wdresetN <= 1'b1;
      r_vblankD  <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_wdresetN <= (w_nextState != FIRE);
      r_vblankD  <= bus.vblank;
      r_armed    <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if ((r_state != RUN) || w_trip || !bus.ch_en[i] || !bus.wdog_n[i])
          r_cnt[i] <= '0;
        else if (w_edge && bus.wdis_n && (r_cnt[i] != TRIP_V))
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulseCnt <= 8'd0;
      r_holdCnt  <= 4'd0;
    end else begin
      r_pulseCnt <= ((r_state == FIRE) && !w_pulseDone) ? r_pulseCnt + 8'd1 : 8'd0;
      if (r_state != HOLD || w_holdDone)
        r_holdCnt <= 4'd0;
      else if (w_edge)
        r_holdCnt <= r_holdCnt + 4'd1;
    end
  end

  // A new trip mask takes precedence over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tripCause <= '0;
      r_tripCount <= 8'd0;
    end else if (w_trip) begin
      r_tripCause <= w_tripMask;
      r_tripCount <= (r_tripCount == 8'd255) ? 8'd255 : r_tripCount + 8'd1;
    end else if (bus.clr_cause) begin
      r_tripCause <= '0;
    end
  end

  assign bus.wdreset_n  = r_wdresetN;
  assign bus.warn       = w_warn;
  assign bus.trip_cause = r_tripCause;
  assign bus.trip_count = r_tripCount;

endmodule

// File: tb/tb_watchdog_multi.sv
// Directed bench for watchdog_multi at default parameters. Each task covers one
// scenario, and expected values come from hand-worked vblank/clock timing.
module tb_watchdog_multi;

  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;

  watchdog_multi_if #(.NCH(2)) bus ();

  watchdog_multi #(
    .NCH(2), .CNT_W(4), .TRIP(8), .WARN(6), .PULSE_LEN(16), .HOLD_EDGES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reset with the inputs in their idle state. The caller chooses the vblank level held through release.
  task automatic doReset(input logic vb);
    reset = 1'b1;
    bus.wdis_n = 1'b1;
    bus.wdog_n = 2'b11;
    bus.ch_en = 2'b11;
    bus.vblank = vb;
    bus.clr_cause = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // A single vblank rising edge, optionally with kicks on the same clock.
  // The task returns at the negedge after the edge has been registered.
  task automatic doEdge(input logic [1:0] kick);
    @(negedge clk);
    bus.vblank = 1'b1;
    bus.wdog_n = ~kick;
    @(negedge clk);
    bus.vblank = 1'b0;
    bus.wdog_n = 2'b11;
  endtask

  // Measures the next reset pulse, with a bounded wait.
  // startDelay is the index of the first low negedge, or -1 if none is seen.
  task automatic waitPulse(output int lowLen, output int startDelay);
    lowLen = 0;
    startDelay = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.wdreset_n === 1'b0) begin
        if (startDelay < 0) startDelay = c;
        lowLen++;
      end else if (lowLen > 0) begin
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wdis_n = 1'b1; bus.wdog_n = 2'b11; bus.ch_en = 2'b11;
    bus.vblank = 1'b0; bus.clr_cause = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (bus.wdreset_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_wdreset_n: got %b expected 1", bus.wdreset_n); end
    testsRun++;
    if (bus.warn !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_warn: got %b expected 00", bus.warn); end
    testsRun++;
    if (bus.trip_cause !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_trip_cause: got %b expected 00", bus.trip_cause); end
    testsRun++;
    if (bus.trip_count !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_trip_count: got %0d expected 0", bus.trip_count); end
    reset = 1'b0;
  endtask

  task automatic test_trip();
    int lowLen, startDelay;
    doReset(1'b0);
    for (int e = 1; e <= 8; e++) begin
      doEdge(2'b00);
      if (e == 5) begin
        testsRun++;
        if (bus.warn !== 2'b00) begin testsFailed++; $display("[TB] FAIL trip_warn_edge5: got %b expected 00", bus.warn); end
      end
      if (e == 6) begin
        testsRun++;
        if (bus.warn !== 2'b11) begin testsFailed++; $display("[TB] FAIL trip_warn_edge6: got %b expected 11", bus.warn); end
      end
    end
    testsRun++;
    if (bus.wdreset_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL trip_early_pulse: got %b expected 1", bus.wdreset_n); end
    waitPulse(lowLen, startDelay);
    testsRun++;
    if (startDelay != 1) begin testsFailed++; $display("[TB] FAIL trip_pulse_start: got %0d expected 1", startDelay); end
    testsRun++;
    if (lowLen != 16) begin testsFailed++; $display("[TB] FAIL trip_pulse_len: got %0d expected 16", lowLen); end
    testsRun++;
    if (bus.trip_cause !== 2'b11) begin testsFailed++; $display("[TB] FAIL trip_cause: got %b expected 11", bus.trip_cause); end
    testsRun++;
    if (bus.trip_count !== 8'd1) begin testsFailed++; $display("[TB] FAIL trip_count: got %0d expected 1", bus.trip_count); end
    testsRun++;
    if (bus.warn !== 2'b00) begin testsFailed++; $display("[TB] FAIL trip_warn_hold: got %b expected 00", bus.warn); end
  endtask

  task automatic test_holdoff();
    int lowLen, startDelay, lows;
    doReset(1'b0);
    repeat (8) doEdge(2'b00);
    waitPulse(lowLen, startDelay);
    repeat (2) doEdge(2'b00);
    repeat (7) doEdge(2'b00);
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.wdreset_n !== 1'b1) lows++;
    end
    testsRun++;
    if (lows != 0) begin testsFailed++; $display("[TB] FAIL hold_no_pulse: got %0d low clocks expected 0", lows); end
    testsRun++;
    if (bus.warn !== 2'b11) begin testsFailed++; $display("[TB] FAIL hold_warn7: got %b expected 11", bus.warn); end
    doEdge(2'b00);
    waitPulse(lowLen, startDelay);
    testsRun++;
    if (lowLen != 16) begin testsFailed++; $display("[TB] FAIL hold_second_pulse: got %0d expected 16", lowLen); end
    testsRun++;
    if (bus.trip_count !== 8'd2) begin testsFailed++; $display("[TB] FAIL hold_trip_count: got %0d expected 2", bus.trip_count); end
  endtask

  task automatic test_kick();
    int lowLen, startDelay, warn0;
    doReset(1'b0);
    warn0 = 0;
    for (int e = 1; e <= 8; e++) begin
      doEdge((e == 5) ? 2'b01 : 2'b00);
      if (bus.warn[0] !== 1'b0) warn0++;
      if (e == 6) begin
        testsRun++;
        if (bus.warn !== 2'b10) begin testsFailed++; $display("[TB] FAIL kick_warn_edge6: got %b expected 10", bus.warn); end
      end
    end
    testsRun++;
    if (warn0 != 0) begin testsFailed++; $display("[TB] FAIL kick_ch0_warned: got %0d edges expected 0", warn0); end
    waitPulse(lowLen, startDelay);
    testsRun++;
    if (lowLen != 16) begin testsFailed++; $display("[TB] FAIL kick_pulse_len: got %0d expected 16", lowLen); end
    testsRun++;
    if (bus.trip_cause !== 2'b10) begin testsFailed++; $display("[TB] FAIL kick_trip_cause: got %b expected 10", bus.trip_cause); end
  endtask

  task automatic test_freeze();
    int lowLen, startDelay, lows;
    doReset(1'b0);
    repeat (5) doEdge(2'b00);
    bus.wdis_n = 1'b0;
    lows = 0;
    for (int e = 1; e <= 20; e++) begin
      doEdge((e == 10) ? 2'b01 : 2'b00);
      if (bus.wdreset_n !== 1'b1) lows++;
    end
    testsRun++;
    if (lows != 0) begin testsFailed++; $display("[TB] FAIL freeze_pulse: got %0d low samples expected 0", lows); end
    testsRun++;
    if (bus.warn !== 2'b00) begin testsFailed++; $display("[TB] FAIL freeze_warn: got %b expected 00", bus.warn); end
    bus.wdis_n = 1'b1;
    doEdge(2'b00);
    testsRun++;
    if (bus.warn !== 2'b10) begin testsFailed++; $display("[TB] FAIL freeze_resume_warn: got %b expected 10", bus.warn); end
    repeat (2) doEdge(2'b00);
    waitPulse(lowLen, startDelay);
    testsRun++;
    if (lowLen != 16) begin testsFailed++; $display("[TB] FAIL freeze_trip_len: got %0d expected 16", lowLen); end
    testsRun++;
    if (bus.trip_cause !== 2'b10) begin testsFailed++; $display("[TB] FAIL freeze_trip_cause: got %b expected 10", bus.trip_cause); end
  endtask

  task automatic test_disabled();
    int lows;
    doReset(1'b0);
    bus.ch_en = 2'b01;
    lows = 0;
    for (int e = 1; e <= 300; e++) begin
      doEdge(2'b01);
      if (bus.wdreset_n !== 1'b1) lows++;
    end
    testsRun++;
    if (lows != 0) begin testsFailed++; $display("[TB] FAIL disabled_pulse: got %0d low samples expected 0", lows); end
    testsRun++;
    if (bus.warn !== 2'b00) begin testsFailed++; $display("[TB] FAIL disabled_warn: got %b expected 00", bus.warn); end
    testsRun++;
    if (bus.trip_count !== 8'd0) begin testsFailed++; $display("[TB] FAIL disabled_trip_count: got %0d expected 0", bus.trip_count); end
  endtask

  task automatic test_saturate();
    int lowLen, startDelay, badPulses;
    doReset(1'b0);
    badPulses = 0;
    for (int t = 1; t <= 256; t++) begin
      repeat (8) doEdge(2'b00);
      waitPulse(lowLen, startDelay);
      if (lowLen != 16) badPulses++;
      repeat (2) doEdge(2'b00);
      if (t == 1 || t == 255 || t == 256) begin
        testsRun++;
        if (bus.trip_count !== ((t == 1) ? 8'd1 : 8'd255)) begin
          testsFailed++;
          $display("[TB] FAIL sat_trip_count_%0d: got %0d expected %0d", t, bus.trip_count, (t == 1) ? 1 : 255);
        end
      end
    end
    testsRun++;
    if (badPulses != 0) begin testsFailed++; $display("[TB] FAIL sat_pulses: got %0d bad pulses expected 0", badPulses); end
  endtask

  task automatic test_clr_cause();
    int lowLen, startDelay;
    doReset(1'b0);
    repeat (8) doEdge(2'b00);
    waitPulse(lowLen, startDelay);
    repeat (2) doEdge(2'b00);
    doEdge(2'b01);
    repeat (6) doEdge(2'b00);
    testsRun++;
    if (bus.trip_cause !== 2'b11) begin testsFailed++; $display("[TB] FAIL clr_sticky: got %b expected 11", bus.trip_cause); end
    doEdge(2'b00);
    bus.clr_cause = 1'b1;
    @(negedge clk);
    bus.clr_cause = 1'b0;
    testsRun++;
    if (bus.trip_cause !== 2'b10) begin testsFailed++; $display("[TB] FAIL clr_on_trip: got %b expected 10", bus.trip_cause); end
    waitPulse(lowLen, startDelay);
    bus.clr_cause = 1'b1;
    @(negedge clk);
    bus.clr_cause = 1'b0;
    testsRun++;
    if (bus.trip_cause !== 2'b00) begin testsFailed++; $display("[TB] FAIL clr_alone: got %b expected 00", bus.trip_cause); end
  endtask

  task automatic test_reset_fire();
    int lowLen, startDelay;
    doReset(1'b0);
    repeat (8) doEdge(2'b00);
    @(negedge clk);
    testsRun++;
    if (bus.wdreset_n !== 1'b0) begin testsFailed++; $display("[TB] FAIL rfire_in_fire: got %b expected 0", bus.wdreset_n); end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    testsRun++;
    if (bus.wdreset_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL rfire_async_release: got %b expected 1", bus.wdreset_n); end
    testsRun++;
    if (bus.trip_count !== 8'd0) begin testsFailed++; $display("[TB] FAIL rfire_trip_count: got %0d expected 0", bus.trip_count); end
    testsRun++;
    if (bus.trip_cause !== 2'b00) begin testsFailed++; $display("[TB] FAIL rfire_trip_cause: got %b expected 00", bus.trip_cause); end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) doEdge(2'b00);
    testsRun++;
    if (bus.warn !== 2'b00) begin testsFailed++; $display("[TB] FAIL rfire_resume_warn: got %b expected 00", bus.warn); end
    repeat (3) doEdge(2'b00);
    waitPulse(lowLen, startDelay);
    testsRun++;
    if (startDelay != 1 || lowLen != 16) begin testsFailed++; $display("[TB] FAIL rfire_resume_trip: got start %0d len %0d expected start 1 len 16", startDelay, lowLen); end
  endtask

  task automatic test_vblank_at_reset();
    doReset(1'b1);
    repeat (4) @(negedge clk);
    bus.vblank = 1'b0;
    @(negedge clk);
    repeat (5) doEdge(2'b00);
    testsRun++;
    if (bus.warn !== 2'b00) begin testsFailed++; $display("[TB] FAIL vbrst_warn5: got %b expected 00", bus.warn); end
    doEdge(2'b00);
    testsRun++;
    if (bus.warn !== 2'b11) begin testsFailed++; $display("[TB] FAIL vbrst_warn6: got %b expected 11", bus.warn); end
  endtask

  initial begin
    test_reset();
    test_trip();
    test_holdoff();
    test_kick();
    test_freeze();
    test_disabled();
    test_clr_cause();
    test_reset_fire();
    test_vblank_at_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got %0d tests run expected completion", testsRun);
    $fatal(1, "[TB] timeout");
  end

endmodule
